// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end: default pixel width and the
// window generator's control states.
package cnn_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One row of pixel storage: synchronous write, combinational read, one shared
// address so a location can be read and overwritten on the same edge.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every location is written in a frame before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Turns a raster pixel stream into unpadded 3x3 windows and hands each one to
// the convolution engine, stalling the stream until the engine finishes.
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic              conv_start,
  input  logic              conv_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  win_state_e        state, state_next;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] win [9];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              accept, col_last, row_last, win_ready;

  assign pix_ready  = (state == FILL) && !rst;
  assign accept     = pix_valid && pix_ready;
  assign conv_start = (state == ISSUE);
  assign busy       = (state != FILL);
  assign col_last   = (col == CW'(IMG_W - 1));
  assign row_last   = (row == RW'(IMG_H - 1));
  assign win_ready  = (row >= RW'(2)) && (col >= CW'(2));

  // lb0 holds row r-1, lb1 holds row r-2; lb1 inherits lb0's old entry.
  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // NOTE: next-state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && win_ready) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (conv_done) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // NOTE: non-blocking assignments let the window shift read the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      state      <= state_next;
      // Counters have already wrapped when the frame's last window is waiting.
      frame_done <= (state == WAIT) && conv_done && (col == '0) && (row == '0);
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_in;
      end
    end
  end

  assign w0 = win[0];
  assign w1 = win[1];
  assign w2 = win[2];
  assign w3 = win[3];
  assign w4 = win[4];
  assign w5 = win[5];
  assign w6 = win[6];
  assign w7 = win[7];
  assign w8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 5x5 instance checked against an image
// model through a window scoreboard, and a 3x3 instance driving a 3-MAC engine.
module tb_window_gen_3x3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 5x5 instance
  logic       pv5 = 1'b0, cd5 = 1'b0;
  logic [7:0] px5 = 8'd0;
  logic       pr5, cs5, fd5, busy5;
  logic [7:0] w5 [9];
  logic [71:0] win5;
  assign win5 = {w5[0], w5[1], w5[2], w5[3], w5[4], w5[5], w5[6], w5[7], w5[8]};

  // 3x3 instance
  logic       pv3 = 1'b0, cd3 = 1'b0;
  logic [7:0] px3 = 8'd0;
  logic       pr3, cs3, fd3, busy3;
  logic [7:0] w3 [9];
  logic [71:0] win3;
  assign win3 = {w3[0], w3[1], w3[2], w3[3], w3[4], w3[5], w3[6], w3[7], w3[8]};

  window_gen_3x3 #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst(rst), .pix_in(px5), .pix_valid(pv5), .pix_ready(pr5),
    .w0(w5[0]), .w1(w5[1]), .w2(w5[2]), .w3(w5[3]), .w4(w5[4]),
    .w5(w5[5]), .w6(w5[6]), .w7(w5[7]), .w8(w5[8]),
    .conv_start(cs5), .conv_done(cd5), .frame_done(fd5), .busy(busy5)
  );

  window_gen_3x3 #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .pix_in(px3), .pix_valid(pv3), .pix_ready(pr3),
    .w0(w3[0]), .w1(w3[1]), .w2(w3[2]), .w3(w3[3]), .w4(w3[4]),
    .w5(w3[5]), .w6(w3[6]), .w7(w3[7]), .w8(w3[8]),
    .conv_start(cs3), .conv_done(cd3), .frame_done(fd3), .busy(busy3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = -10;
  int last_done = -10;
  int n_start5 = 0, n_fd5 = 0, n_acc5 = 0;
  int n_start3 = 0, n_fd3 = 0;
  int fd_before;
  logic [71:0] sb [$];
  logic [71:0] first_win = '0, last_win = '0, held = '0;
  bit          hold_on = 1'b0, hold_last = 1'b0;
  logic [15:0] mac_out = '0;

  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_05_06_07_0a_0b_0c;
  localparam logic [71:0] LAST_WIN  = 72'h0c_0d_0e_11_12_13_16_17_18;
  localparam logic [71:0] ONES_WIN  = {9{8'd1}};

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model for the 5x5 instance: conv_done three cycles after conv_start.
  initial forever begin
    @(negedge clk);
    if (cs5 === 1'b1 && !rst) begin
      repeat (3) begin @(posedge clk); #1; end
      cd5 = 1'b1;
      @(posedge clk); #1;
      cd5 = 1'b0;
    end
  end

  // 3-MAC engine for the 3x3 instance: one window row per cycle, unit kernel.
  initial forever begin
    logic [15:0] acc;
    @(negedge clk);
    if (!rst && fd3 === 1'b1) n_fd3++;
    if (cs3 === 1'b1 && !rst) begin
      n_start3++;
      check("t3_window", win3, ONES_WIN);
      acc = '0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        acc = acc + 16'(w3[3*k]) * 16'd1 + 16'(w3[3*k+1]) * 16'd1 + 16'(w3[3*k+2]) * 16'd1;
      end
      mac_out = acc;
      cd3 = 1'b1;
      @(posedge clk); #1;
      cd3 = 1'b0;
    end
  end

  // Monitor for the 5x5 instance: scoreboard pops, latency, stability, handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_on   = 1'b0;
      hold_last = 1'b0;
    end else begin
      check("ready_vs_busy", 72'(pr5), 72'(!busy5));
      if (fd5) begin
        n_fd5++;
        check("frame_done_timing", 72'(cyc), 72'(last_done + 1));
      end
      if (cs5) begin
        n_start5++;
        check("start_latency", 72'(cyc), 72'(last_acc + 1));
        check("sb_has_entry", 72'(sb.size() != 0), 72'(1));
        if (sb.size() != 0) check("window", win5, sb.pop_front());
        if (n_start5 == 1) first_win = win5;
        last_win  = win5;
        held      = win5;
        hold_on   = 1'b1;
        hold_last = 1'b0;
      end else if (hold_on) begin
        check("window_stable", win5, held);
        if (hold_last) begin
          hold_on   = 1'b0;
          hold_last = 1'b0;
        end else if (busy5 && cd5) begin
          hold_last = 1'b1;
        end
      end
      if (busy5 && cd5 && !cs5) last_done = cyc;
      if (pv5 && pr5) begin
        n_acc5++;
        last_acc = cyc;
      end
    end
  end

  task automatic send_px(input int sel, input logic [7:0] v, input int gap);
    int n;
    if (sel == 0) pv5 = 1'b0; else pv3 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    if (sel == 0) begin pv5 = 1'b1; px5 = v; end
    else          begin pv3 = 1'b1; px3 = v; end
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? !pr5 : !pr3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 72'(n), 72'(0));
    @(posedge clk); #1;
    if (sel == 0) pv5 = 1'b0; else pv3 = 1'b0;
  endtask

  // Drives n_px pixels of a 5x5 frame (value base+index); gap<0 means random gaps.
  task automatic send_frame5(input int base, input int n_px, input int gap);
    logic [7:0] img [5][5];
    for (int i = 0; i < n_px; i++) begin
      int r, c;
      r = i / 5;
      c = i % 5;
      img[r][c] = 8'(base + i);
      if (r >= 2 && c >= 2)
        sb.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                      img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                      img[r][c-2],   img[r][c-1],   img[r][c]});
      send_px(0, img[r][c], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    end
  endtask

  task automatic clear_counts();
    n_start5 = 0;
    n_fd5    = 0;
    n_acc5   = 0;
  endtask

  initial begin
    // Test 1: reset with random stimulus
    repeat (2) begin
      @(posedge clk); #1;
      pv5 = 1'($urandom_range(0, 1));
      px5 = 8'($urandom);
      @(negedge clk);
      check("rst_window", win5, 72'(0));
      check("rst_conv_start", 72'(cs5), 72'(0));
      check("rst_frame_done", 72'(fd5), 72'(0));
      check("rst_busy", 72'(busy5), 72'(0));
      check("rst_pix_ready", 72'(pr5), 72'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pv5 = 1'b0;
    @(negedge clk);
    check("post_rst_pix_ready", 72'(pr5), 72'(1));
    check("post_rst_pix_ready_3", 72'(pr3), 72'(1));
    check("post_rst_no_start", 72'(n_start5), 72'(0));

    // Test 2: 5x5 raster frame with idle cycles between pixels
    @(posedge clk); #1;
    clear_counts();
    send_frame5(0, 25, 2);
    repeat (12) begin @(posedge clk); #1; end
    check("t2_starts", 72'(n_start5), 72'(9));
    check("t2_first_window", first_win, FIRST_WIN);
    check("t2_last_window", last_win, LAST_WIN);
    check("t2_frame_done", 72'(n_fd5), 72'(1));
    check("t2_accepted", 72'(n_acc5), 72'(25));
    check("t2_sb_drained", 72'(sb.size()), 72'(0));

    // Test 3: 3x3 frame of ones into the MAC engine
    for (int i = 0; i < 9; i++) send_px(1, 8'd1, 0);
    repeat (12) begin @(posedge clk); #1; end
    check("t3_starts", 72'(n_start3), 72'(1));
    check("t3_mac_out", 72'(mac_out), 72'(9));
    check("t3_frame_done", 72'(n_fd3), 72'(1));

    // Test 4: pix_valid held high across stalls
    clear_counts();
    send_frame5(0, 25, 0);
    repeat (12) begin @(posedge clk); #1; end
    check("t4_starts", 72'(n_start5), 72'(9));
    check("t4_first_window", first_win, FIRST_WIN);
    check("t4_last_window", last_win, LAST_WIN);
    check("t4_frame_done", 72'(n_fd5), 72'(1));
    check("t4_accepted", 72'(n_acc5), 72'(25));

    // Test 5: randomly gapped frame, then a back-to-back frame offset by 100
    clear_counts();
    send_frame5(0, 25, -1);
    send_frame5(100, 25, 0);
    repeat (12) begin @(posedge clk); #1; end
    check("t5_starts", 72'(n_start5), 72'(18));
    check("t5_frame_done", 72'(n_fd5), 72'(2));
    check("t5_accepted", 72'(n_acc5), 72'(50));
    check("t5_sb_drained", 72'(sb.size()), 72'(0));

    // Test 6: reset while waiting on window 4, then a fresh frame
    clear_counts();
    send_frame5(0, 18, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_in_wait", 72'(busy5 && !cs5), 72'(1));
    check("t6_starts_before_rst", 72'(n_start5), 72'(4));
    fd_before = n_fd5;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_busy_after_rst", 72'(busy5), 72'(0));
    check("t6_ready_after_rst", 72'(pr5), 72'(1));
    repeat (6) begin @(posedge clk); #1; end
    check("t6_no_frame_done", 72'(n_fd5), 72'(fd_before));
    clear_counts();
    send_frame5(0, 25, 1);
    repeat (12) begin @(posedge clk); #1; end
    check("t6_first_window", first_win, FIRST_WIN);
    check("t6_starts", 72'(n_start5), 72'(9));
    check("t6_frame_done", 72'(n_fd5), 72'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream feeder for the 3×3 convolution engine.
- Accepts a raster-order pixel stream of one IMG_W×IMG_H frame and keeps the previous two rows in line buffers.
- Assembles each valid (unpadded) 3×3 window, presents it on w0..w8, pulses conv_start and stalls input until the engine reports conv_done.
- Emits (IMG_W-2)×(IMG_H-2) windows per frame.

Parameters:
- DATA_W, 8, pixel width; matches the engine in0..in8 width.
- IMG_W, 8, pixels per row; minimum 3.
- IMG_H, 8, rows per frame; minimum 3.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  DATA_W  input pixel, raster order, row 0 col 0 first.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  block can accept a pixel; transfer happens when pix_valid & pix_ready.
- w0..w8  out  DATA_W each  window; w0..w2 = row r-2 cols c-2..c, w3..w5 = row r-1, w6..w8 = row r; connect to engine in0..in8.
- conv_start  out  1  one-cycle pulse; window is valid and stable.
- conv_done  in  1  engine finished the current window.
- frame_done  out  1  one-cycle pulse after the final window of the frame completes.
- busy  out  1  high in ISSUE or WAIT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FILL, col=0, row=0.
  - w0..w8=0, conv_start=0, frame_done=0, busy=0.
  - pix_ready=1 from the first cycle after rst deasserts.
  - Line buffer contents are don't-care; they are never read before being written in a frame.
  - rst overrides everything, including mid-WAIT; the interrupted window is discarded.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1; both advance only on an accepted pixel.
  - col wraps to 0 and row increments.
  - At col=IMG_W-1 and row=IMG_H-1 both wrap to 0; the next frame starts seamlessly.
- Line buffers: two buffers, lb0 holding row r-1 and lb1 holding row r-2, each IMG_W deep and addressed by col. On an accepted pixel, in the same edge:
  - read lb0[col] and lb1[col];
  - write lb1[col] <= lb0[col] and lb0[col] <= pix_in (read-before-write);
  - shift the window left one column (w0<=w1, w1<=w2, ...);
  - load the new right column: w2<=lb1[col], w5<=lb0[col], w8<=pix_in.
- FSM:
  - FILL: pix_ready=1. An accepted pixel with row>=2 and col>=2 goes to ISSUE; otherwise stay in FILL.
  - ISSUE: lasts exactly 1 cycle. conv_start=1, pix_ready=0, conv_done ignored. Always goes to WAIT.
  - WAIT: pix_ready=0. When conv_done=1, go to FILL; if that window was the last of the frame (row=0, col=0 after wrap), also pulse frame_done in the following cycle.
- Latency and stability:
  - If the window-completing pixel is accepted in cycle t, conv_start=1 in cycle t+1.
  - w0..w8 stay unchanged from t+1 through the cycle after conv_done.
  - Earliest next pixel acceptance is the cycle after conv_done is sampled.
- Boundaries:
  - Windows never straddle rows; the shift registers reload with col 0..1 of each row before the next window.
  - pix_valid while pix_ready=0 is not consumed; the source must hold the pixel.
  - conv_done in FILL is ignored.
  - Unsigned data; no arithmetic beyond the counters.
  - Counter width is $clog2(IMG_W) and $clog2(IMG_H).

Decomposition:
- Shared package cnn_pkg: DATA_W default, FSM state encodings (FILL, ISSUE, WAIT).
- One sub-module, line_buffer: single-port-address RAM with synchronous write and combinational read, parameters DATA_W and DEPTH; instantiated twice.

Test Plan:
1. Reset: rst high for 2 cycles with random inputs -> all outputs 0; pix_ready=1 the cycle after release; no conv_start.
2. IMG_W=5, IMG_H=5, pixel value = raster index 0..24, model engine asserts done 3 cycles after start:
   - exactly 9 conv_start pulses;
   - first window = 0,1,2,5,6,7,10,11,12, with conv_start the cycle after pixel 12 is accepted;
   - last window = 12,13,14,17,18,19,22,23,24;
   - frame_done pulses once, the cycle after the last conv_done.
3. IMG_W=3, IMG_H=3, all pixels 1, real 3-MAC engine attached -> one window, all ones, engine out=9, frame_done once.
4. pix_valid held high continuously on a 5×5 frame -> pix_ready low from each ISSUE through its done cycle; 25 pixels accepted with none duplicated; windows match test 2.
5. Randomly gapped pix_valid, then a second back-to-back frame (values +100) -> window sequences match the golden model for both frames.
6. rst asserted during WAIT of window 4 -> FILL, counters 0, no frame_done; a fresh 5×5 frame then produces a correct first window (0,1,2,5,6,7,10,11,12).
